// File: rtl/seq_chunk_addsub.sv
// seq_chunk_addsub
//   Multi-cycle adder/subtractor. WIDTH-bit operands are summed CHUNK bits per
//   clock through a single CHUNK-bit ripple stage, with the carry held in a
//   register between chunks. A start/busy/done handshake fronts the block.
//   Subtraction is a + ~b + 1, with the carry-in seeded to 1.
// Ports
//   clk    clock, rising edge
//   rst    asynchronous active-high reset
//   start  request an operation (sampled only when not busy)
//   sub    0: a+b, 1: a-b (sampled with start)
//   a, b   WIDTH-bit operands (sampled with start)
//   busy   high while chunks are being processed
//   done   one-cycle pulse, results valid from this cycle
//   sum    registered result, held until the next result is loaded
//   cout   carry out of the MSB (sub: 1 = no borrow)
//   ovf    signed overflow (carry into MSB xor carry out of MSB)
module seq_chunk_addsub #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int unsigned NCHUNK = WIDTH / CHUNK;
   localparam int unsigned IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t state, state_next;

   logic [WIDTH-1:0] op_a, op_b, sum_acc, acc_next;
   logic             carry;
   logic [IDXW-1:0]  idx;
   logic [31:0]      base;
   logic [CHUNK-1:0] chunk_a, chunk_b, chunk_s;
   logic             chunk_c, msb_cin;
   logic             last, accept;

   assign busy   = (state == RUN);
   assign done   = (state == DONE);
   assign last   = (idx == IDXW'(NCHUNK - 1));
   // start is only honoured outside RUN, so an in-flight op cannot be disturbed
   assign accept = start && (state != RUN);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (accept) state_next = RUN;
         RUN:     if (last)   state_next = DONE;
         DONE:    state_next = accept ? RUN : IDLE;
         default: state_next = IDLE;
      endcase
   end

   // One CHUNK-bit ripple stage; the carry into the top bit of the chunk is
   // recovered from the sum bit, which on the final chunk is the MSB carry-in.
   always_comb begin
      base     = 32'(idx) * CHUNK;
      chunk_a  = op_a[base +: CHUNK];
      chunk_b  = op_b[base +: CHUNK];
      {chunk_c, chunk_s} = {1'b0, chunk_a} + {1'b0, chunk_b} + (CHUNK + 1)'(carry);
      msb_cin  = chunk_s[CHUNK-1] ^ chunk_a[CHUNK-1] ^ chunk_b[CHUNK-1];
      acc_next = sum_acc;
      acc_next[base +: CHUNK] = chunk_s;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_a    <= '0;
         op_b    <= '0;
         carry   <= 1'b0;
         idx     <= '0;
         sum_acc <= '0;
         sum     <= '0;
         cout    <= 1'b0;
         ovf     <= 1'b0;
      end else if (accept) begin
         op_a  <= a;
         op_b  <= sub ? ~b : b;
         carry <= sub;
         idx   <= '0;
      end else if (state == RUN) begin
         sum_acc <= acc_next;
         carry   <= chunk_c;
         idx     <= idx + 1'b1;
         if (last) begin
            sum  <= acc_next;
            cout <= chunk_c;
            ovf  <= chunk_c ^ msb_cin;
         end
      end
   end

endmodule

// File: tb/tb_seq_chunk_addsub.sv
// tb_seq_chunk_addsub
//   Directed bench for seq_chunk_addsub: a 16/4 instance for latency, flags,
//   busy-ignore, back-to-back and reset abort; a 4/4 instance for the
//   single-chunk case and an exhaustive 4-bit sweep.
module tb_seq_chunk_addsub;

   logic        clk = 1'b0;
   logic        rst;
   logic        start, sub;
   logic [15:0] a, b;
   logic        busy, done, cout, ovf;
   logic [15:0] sum;

   logic        s_start, s_sub;
   logic [3:0]  s_a, s_b;
   logic        s_busy, s_done, s_cout, s_ovf;
   logic [3:0]  s_sum;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   seq_chunk_addsub #(.WIDTH(16), .CHUNK(4)) dut (
      .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
      .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
   );

   seq_chunk_addsub #(.WIDTH(4), .CHUNK(4)) dut_small (
      .clk(clk), .rst(rst), .start(s_start), .sub(s_sub), .a(s_a), .b(s_b),
      .busy(s_busy), .done(s_done), .sum(s_sum), .cout(s_cout), .ovf(s_ovf)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Start one op at the next edge (E0), check busy/done and that sum holds
   // its previous value through E1..E3, then results in the done cycle after E4.
   task automatic do_op(input string tag, input logic s, input logic [15:0] x, input logic [15:0] y,
                        input logic [15:0] prev, input logic [15:0] exp_sum,
                        input logic exp_c, input logic exp_v);
      start = 1'b1; sub = s; a = x; b = y;
      tick();
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check({tag, " busy"}, 32'(busy), 32'd1);
         check({tag, " done_early"}, 32'(done), 32'd0);
         check({tag, " sum_hold"}, 32'(sum), 32'(prev));
         tick();
      end
      check({tag, " done"}, 32'(done), 32'd1);
      check({tag, " busy_end"}, 32'(busy), 32'd0);
      check({tag, " sum"}, 32'(sum), 32'(exp_sum));
      check({tag, " cout"}, 32'(cout), 32'(exp_c));
      check({tag, " ovf"}, 32'(ovf), 32'(exp_v));
   endtask

   initial begin
      logic [4:0] ref_full;
      logic [3:0] ref_b;
      logic       ref_v;

      rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
      s_start = 1'b0; s_sub = 1'b0; s_a = '0; s_b = '0;
      #1;
      check("rst busy", 32'(busy), 32'd0);
      check("rst done", 32'(done), 32'd0);
      check("rst sum",  32'(sum),  32'd0);
      check("rst cout", 32'(cout), 32'd0);
      check("rst ovf",  32'(ovf),  32'd0);
      tick();
      rst = 1'b0;
      tick();

      // 1: latency and single-cycle done pulse
      do_op("t1", 1'b0, 16'h1234, 16'h0FFF, 16'h0000, 16'h2233, 1'b0, 1'b0);
      tick();
      check("t1 done_pulse", 32'(done), 32'd0);
      check("t1 sum_keep", 32'(sum), 32'h2233);

      // 2/3: carry, overflow, borrow
      do_op("t2a", 1'b0, 16'hFFFF, 16'h0001, 16'h2233, 16'h0000, 1'b1, 1'b0);
      tick();
      do_op("t2b", 1'b0, 16'h7FFF, 16'h0001, 16'h0000, 16'h8000, 1'b0, 1'b1);
      tick();
      do_op("t3a", 1'b1, 16'h0005, 16'h0007, 16'h8000, 16'hFFFE, 1'b0, 1'b0);
      tick();
      do_op("t3b", 1'b1, 16'h8000, 16'h0001, 16'hFFFE, 16'h7FFF, 1'b1, 1'b1);
      tick();

      // 4: start while busy is ignored; back-to-back start in the done cycle
      start = 1'b1; sub = 1'b0; a = 16'h0001; b = 16'h0001;
      tick();                       // E0
      start = 1'b0;
      tick();                       // E1
      start = 1'b1; a = 16'hAAAA;   // seen at E2 while busy
      tick();                       // E2
      start = 1'b0; a = 16'h0001;
      tick();                       // E3
      check("t4 done_early", 32'(done), 32'd0);
      tick();                       // E4
      check("t4 done", 32'(done), 32'd1);
      check("t4 sum", 32'(sum), 32'h0002);
      start = 1'b1; a = 16'h0003; b = 16'h0004;
      tick();                       // E5: accepted from DONE
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("t4 b2b_busy", 32'(busy), 32'd1);
         check("t4 b2b_nodone", 32'(done), 32'd0);
         tick();
      end
      check("t4 b2b_done", 32'(done), 32'd1);
      check("t4 b2b_sum", 32'(sum), 32'h0007);
      tick();

      // 5: asynchronous reset mid-operation
      do_op("t5pre", 1'b1, 16'h8000, 16'h0001, 16'h0007, 16'h7FFF, 1'b1, 1'b1);
      tick();
      start = 1'b1; sub = 1'b0; a = 16'h1234; b = 16'h0FFF;
      tick();                       // E0
      start = 1'b0;
      tick();                       // E1
      rst = 1'b1;
      #1;
      check("t5 busy", 32'(busy), 32'd0);
      check("t5 done", 32'(done), 32'd0);
      check("t5 sum",  32'(sum),  32'd0);
      check("t5 cout", 32'(cout), 32'd0);
      check("t5 ovf",  32'(ovf),  32'd0);
      tick();
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         check("t5 no_done", 32'(done), 32'd0);
         tick();
      end
      do_op("t5post", 1'b0, 16'h00FF, 16'h0001, 16'h0000, 16'h0100, 1'b0, 1'b0);
      tick();

      // 6: single-chunk instance
      s_start = 1'b1; s_sub = 1'b0; s_a = 4'hF; s_b = 4'hF;
      tick();                       // E0
      s_start = 1'b0;
      check("t6 busy", 32'(s_busy), 32'd1);
      check("t6 done_early", 32'(s_done), 32'd0);
      tick();                       // E1
      check("t6 done", 32'(s_done), 32'd1);
      check("t6 sum",  32'(s_sum),  32'hE);
      check("t6 cout", 32'(s_cout), 32'd1);
      check("t6 ovf",  32'(s_ovf),  32'd0);
      tick();

      for (int m = 0; m < 2; m++) begin
         for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
               ref_b    = (m == 1) ? ~4'(y) : 4'(y);
               ref_full = {1'b0, 4'(x)} + {1'b0, ref_b} + 5'(m);
               ref_v    = (4'(x) >> 3 == ref_b >> 3) && (ref_full[3] != 4'(x) >> 3);
               s_start = 1'b1; s_sub = m[0]; s_a = 4'(x); s_b = 4'(y);
               tick();
               s_start = 1'b0;
               tick();
               check("sweep done", 32'(s_done), 32'd1);
               check("sweep sum",  32'(s_sum),  32'(ref_full[3:0]));
               check("sweep cout", 32'(s_cout), 32'(ref_full[4]));
               check("sweep ovf",  32'(s_ovf),  32'(ref_v));
            end
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
